// File: rtl/video_out_lb_ctrl.sv
// video_out_lb_ctrl: ping-pong line-buffer capture, magnified readout and aligned output timing
module video_out_lb_ctrl #(
  parameter int   h_total        = 1368,
  parameter int   v_total        = 524,
  parameter int   wr_h_start     = 200,
  parameter int   wr_width       = 512,
  parameter int   rd_h_start     = 240,
  parameter int   rd_width       = 720,
  parameter int   mag_step       = 728,
  parameter int   hs_start       = 0,
  parameter int   hs_width       = 100,
  parameter int   vs_line        = 0,
  parameter int   vs_width       = 6,
  parameter int   v_active_start = 40,
  parameter int   v_active_lines = 480,
  parameter logic hs_positive    = 1'b0,
  parameter logic vs_positive    = 1'b0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [5:0]  vdp_r_i,
  input  logic [5:0]  vdp_g_i,
  input  logic [5:0]  vdp_b_i,
  input  logic [10:0] vdp_hcounter_i,
  input  logic [10:0] vdp_vcounter_i,
  output logic        lb_we_o,
  output logic        lb_wbank_o,
  output logic [9:0]  lb_waddr_o,
  output logic [17:0] lb_wdata_o,
  output logic        lb_re_o,
  output logic        lb_rbank_o,
  output logic [9:0]  lb_raddr_o,
  output logic        video_de_o,
  output logic        video_hs_o,
  output logic        video_vs_o
);
  localparam logic [10:0] H_LAST   = 11'(h_total - 1);
  localparam logic [10:0] WR_START = 11'(wr_h_start);
  localparam logic [10:0] WR_W     = 11'(wr_width);
  localparam logic [9:0]  WR_MAX   = 10'(wr_width - 1);
  localparam logic [10:0] RD_START = 11'(rd_h_start);
  localparam logic [10:0] RD_W     = 11'(rd_width);
  localparam logic [19:0] STEP     = 20'(mag_step);
  localparam logic [10:0] HS_A     = 11'(hs_start);
  localparam logic [10:0] HS_W     = 11'(hs_width);
  localparam logic [10:0] VS_A     = 11'(vs_line);
  localparam logic [10:0] VS_W     = 11'(vs_width);
  localparam logic [10:0] VA_A     = 11'(v_active_start);
  localparam logic [10:0] VA_N     = 11'(v_active_lines);
  localparam logic [10:0] V_TOT    = 11'(v_total);
  typedef enum logic [1:0] {W_WAIT, W_CAP, W_DONE} wstate_t;
  typedef enum logic {R_IDLE, R_ACT} rstate_t;
  wstate_t     w_state_q, w_state_d;
  rstate_t     r_state_q, r_state_d;
  logic [10:0] wcount_q, wcount_d, rcount_q, rcount_d, rcount_n, ly_q, ly_d;
  logic [19:0] acc_q, acc_d, acc_base;
  logic [17:0] wdata_q, wdata_d;
  logic [9:0]  waddr_q, waddr_d, raddr_q, raddr_d;
  logic        we_q, we_d, re_q, re_d, wbank_q, wbank_d, line_valid_q, line_valid_d;
  logic        de_q, de_d, hs_p_q, hs_p_d, hs_q, vs_p_q, vs_p_d, vs_q;
  logic        swap, cap, rd_go, rd_first, vact;
  assign swap     = vdp_hcounter_i == H_LAST;
  assign cap      = (w_state_q == W_CAP || (w_state_q == W_WAIT && vdp_hcounter_i == WR_START)) && wcount_q < WR_W;
  // unsigned subtraction turns each [start, start+width) window test into one compare
  assign vact     = line_valid_q && (ly_q - VA_A) < VA_N && ly_q < V_TOT;
  assign rd_first = r_state_q == R_IDLE;
  assign rd_go    = !rd_first || vdp_hcounter_i == RD_START;
  assign acc_base = rd_first ? '0 : acc_q;
  assign rcount_n = (rd_first ? 11'd0 : rcount_q) + 11'd1;
  always_comb begin
    w_state_d    = w_state_q;
    wcount_d     = wcount_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wbank_d      = swap ? ~wbank_q : wbank_q;
    ly_d         = swap ? vdp_vcounter_i : ly_q;
    line_valid_d = swap | line_valid_q;
    if (swap) begin
      w_state_d = W_WAIT;
      wcount_d  = '0;
    end else if (cap) begin
      w_state_d = W_CAP;
      if (enable_i) begin
        we_d     = 1'b1;
        waddr_d  = wcount_q[9:0];
        wdata_d  = {vdp_r_i, vdp_g_i, vdp_b_i};
        wcount_d = wcount_q + 11'd1;
      end
    end else if (w_state_q == W_CAP) begin
      w_state_d = W_DONE;
    end
  end
  always_comb begin
    re_d      = rd_go;
    raddr_d   = rd_go ? (acc_base[19:10] > WR_MAX ? WR_MAX : acc_base[19:10]) : raddr_q;
    acc_d     = rd_go ? acc_base + STEP : acc_q;
    rcount_d  = rd_go ? rcount_n : rcount_q;
    r_state_d = (rd_go && rcount_n != RD_W) ? R_ACT : R_IDLE;
    de_d      = re_q && vact;
    hs_p_d    = ((vdp_hcounter_i - HS_A) < HS_W) ? hs_positive : ~hs_positive;
    vs_p_d    = ((ly_q - VS_A) < VS_W) ? vs_positive : ~vs_positive;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_state_q    <= W_WAIT;
      wcount_q     <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wbank_q      <= 1'b0;
      ly_q         <= '0;
      line_valid_q <= 1'b0;
      r_state_q    <= R_IDLE;
      rcount_q     <= '0;
      acc_q        <= '0;
      re_q         <= 1'b0;
      raddr_q      <= '0;
      de_q         <= 1'b0;
      hs_p_q       <= ~hs_positive;
      hs_q         <= ~hs_positive;
      vs_p_q       <= ~vs_positive;
      vs_q         <= ~vs_positive;
    end else begin
      w_state_q    <= w_state_d;
      wcount_q     <= wcount_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wbank_q      <= wbank_d;
      ly_q         <= ly_d;
      line_valid_q <= line_valid_d;
      r_state_q    <= r_state_d;
      rcount_q     <= rcount_d;
      acc_q        <= acc_d;
      re_q         <= re_d;
      raddr_q      <= raddr_d;
      de_q         <= de_d;
      hs_p_q       <= hs_p_d;
      hs_q         <= hs_p_q;
      vs_p_q       <= vs_p_d;
      vs_q         <= vs_p_q;
    end
  end
  assign lb_we_o    = we_q;
  assign lb_wbank_o = wbank_q;
  assign lb_waddr_o = waddr_q;
  assign lb_wdata_o = wdata_q;
  assign lb_re_o    = re_q;
  assign lb_rbank_o = ~wbank_q;
  assign lb_raddr_o = raddr_q;
  assign video_de_o = de_q;
  assign video_hs_o = hs_q;
  assign video_vs_o = vs_q;
endmodule

// File: tb/tb_video_out_lb_ctrl.sv
// tb_video_out_lb_ctrl: directed line-by-line stimulus with per-scenario inline checks
module tb_video_out_lb_ctrl;
  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [5:0]  r = '0, g = '0, b = '0;
  logic [10:0] hc = '0, vc = '0;
  logic        lb_we, lb_wbank, lb_re, lb_rbank, video_de, video_hs, video_vs;
  logic [9:0]  lb_waddr, lb_raddr;
  logic [17:0] lb_wdata;
  int checks = 0, failures = 0;
  int gap_lo = -1, gap_hi = -1;
  int we_n, w_bad, w_gap, w_last_hc, re_n, re_first, bank_bad, de_n, de_first, hs_lo;
  logic [9:0] w_last, r_max;
  logic [9:0] rseq [6];
  logic vs_mid, exp_bank;

  video_out_lb_ctrl dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable),
    .vdp_r_i(r), .vdp_g_i(g), .vdp_b_i(b),
    .vdp_hcounter_i(hc), .vdp_vcounter_i(vc),
    .lb_we_o(lb_we), .lb_wbank_o(lb_wbank), .lb_waddr_o(lb_waddr), .lb_wdata_o(lb_wdata),
    .lb_re_o(lb_re), .lb_rbank_o(lb_rbank), .lb_raddr_o(lb_raddr),
    .video_de_o(video_de), .video_hs_o(video_hs), .video_vs_o(video_vs)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pix(input int h, input int v);
    return {6'(h >> 1), 6'(h >> 7), 6'(v)};
  endfunction

  task automatic clear_stats();
    we_n = 0; w_bad = 0; w_gap = 0; w_last_hc = -1; w_last = '0;
    re_n = 0; re_first = -1; r_max = '0; bank_bad = 0;
    de_n = 0; de_first = -1; hs_lo = 0; vs_mid = 1'bx;
    for (int i = 0; i < 6; i++) rseq[i] = '1;
  endtask

  // each sample after an edge shows the registered response to the inputs held at that edge
  task automatic run_hc(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      hc = 11'(h); vc = 11'(v);
      enable = (h % 2 == 0) && !(h >= gap_lo && h < gap_hi);
      {r, g, b} = pix(h, v);
      @(posedge clk); #1;
      if (lb_we) begin
        if (lb_waddr !== 10'(we_n) || lb_wdata !== pix(h, v)) w_bad++;
        if (h >= gap_lo && h < gap_hi) w_gap++;
        w_last = lb_waddr; w_last_hc = h; we_n++;
      end
      if (lb_re) begin
        if (re_n == 0) re_first = h;
        if (re_n < 6) rseq[re_n] = lb_raddr;
        if (lb_raddr > r_max) r_max = lb_raddr;
        re_n++;
      end
      if (lb_rbank === lb_wbank) bank_bad++;
      if (video_de) begin
        if (de_n == 0) de_first = h;
        de_n++;
      end
      if (video_hs === 1'b0) hs_lo++;
      if (h == 500) vs_mid = video_vs;
    end
  endtask

  task automatic run_line(input int v);
    clear_stats();
    run_hc(v, 0, 1367);
    exp_bank = ~exp_bank;
  endtask

  task automatic test_reset();
    reset = 1'b1; hc = '0; vc = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({lb_we, lb_re, video_de} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b want=000", {lb_we, lb_re, video_de}); end
    checks++; if ({lb_wbank, lb_rbank} !== 2'b01) begin failures++; $display("FAIL reset_banks got=%b want=01", {lb_wbank, lb_rbank}); end
    checks++; if ({lb_waddr, lb_raddr, lb_wdata} !== 38'd0) begin failures++; $display("FAIL reset_addr_data got=%h/%h/%h want=0", lb_waddr, lb_raddr, lb_wdata); end
    checks++; if ({video_hs, video_vs} !== 2'b11) begin failures++; $display("FAIL reset_syncs got=%b want=11", {video_hs, video_vs}); end
    reset = 1'b0; exp_bank = 1'b0;
  endtask

  task automatic test_first_line();
    run_line(0);
    checks++; if (de_n !== 0) begin failures++; $display("FAIL first_line_de got=%0d want=0", de_n); end
    checks++; if (hs_lo !== 100) begin failures++; $display("FAIL first_line_hs got=%0d want=100", hs_lo); end
    checks++; if (vs_mid !== 1'b0) begin failures++; $display("FAIL first_line_vs got=%b want=0", vs_mid); end
    checks++; if (lb_wbank !== 1'b1) begin failures++; $display("FAIL first_swap_bank got=%b want=1", lb_wbank); end
  endtask

  task automatic test_capture();
    run_line(1);
    checks++; if (we_n !== 512) begin failures++; $display("FAIL capture_count got=%0d want=512", we_n); end
    checks++; if (w_bad !== 0) begin failures++; $display("FAIL capture_addr_data got=%0d bad want=0", w_bad); end
    checks++; if (w_last !== 10'd511) begin failures++; $display("FAIL capture_last_addr got=%0d want=511", w_last); end
    checks++; if (w_last_hc !== 1222) begin failures++; $display("FAIL capture_last_hc got=%0d want=1222", w_last_hc); end
    checks++; if (lb_wbank !== exp_bank) begin failures++; $display("FAIL capture_bank got=%b want=%b", lb_wbank, exp_bank); end
  endtask

  task automatic test_readout();
    run_line(2);
    checks++; if (re_n !== 720) begin failures++; $display("FAIL read_count got=%0d want=720", re_n); end
    checks++; if (re_first !== 240) begin failures++; $display("FAIL read_first_hc got=%0d want=240", re_first); end
    checks++; if ({rseq[0], rseq[1], rseq[2], rseq[3], rseq[4], rseq[5]} !== {10'd0, 10'd0, 10'd1, 10'd2, 10'd2, 10'd3})
      begin failures++; $display("FAIL read_addr_seq got=%0d,%0d,%0d,%0d,%0d,%0d want=0,0,1,2,2,3", rseq[0], rseq[1], rseq[2], rseq[3], rseq[4], rseq[5]); end
    checks++; if (r_max !== 10'd511) begin failures++; $display("FAIL read_max_addr got=%0d want=511", r_max); end
    checks++; if (bank_bad !== 0) begin failures++; $display("FAIL read_bank_equal got=%0d cycles want=0", bank_bad); end
    checks++; if (lb_wbank !== exp_bank) begin failures++; $display("FAIL read_bank got=%b want=%b", lb_wbank, exp_bank); end
  endtask

  task automatic test_vertical();
    int vcs [8]    = '{39, 40, 41, 519, 520, 5, 6, 7};
    int exp_de [8] = '{0, 0, 720, 720, 720, 0, 0, 0};
    logic exp_vs [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      run_line(vcs[i]);
      checks++; if (de_n !== exp_de[i]) begin failures++; $display("FAIL vert_de vc=%0d got=%0d want=%0d", vcs[i], de_n, exp_de[i]); end
      checks++; if (vs_mid !== exp_vs[i]) begin failures++; $display("FAIL vert_vs vc=%0d got=%b want=%b", vcs[i], vs_mid, exp_vs[i]); end
      if (exp_de[i] == 720) begin
        checks++; if (de_first !== 241) begin failures++; $display("FAIL vert_de_first vc=%0d got=%0d want=241", vcs[i], de_first); end
      end
    end
  endtask

  task automatic test_enable_gap();
    gap_lo = 300; gap_hi = 310;
    run_line(100);
    gap_lo = -1; gap_hi = -1;
    checks++; if (w_gap !== 0) begin failures++; $display("FAIL gap_writes got=%0d want=0", w_gap); end
    checks++; if (we_n !== 512) begin failures++; $display("FAIL gap_count got=%0d want=512", we_n); end
    checks++; if (w_bad !== 0) begin failures++; $display("FAIL gap_addr_data got=%0d bad want=0", w_bad); end
    checks++; if (w_last_hc !== 1232) begin failures++; $display("FAIL gap_last_hc got=%0d want=1232", w_last_hc); end
  endtask

  task automatic test_reset_midline();
    clear_stats();
    run_hc(200, 0, 599);
    checks++; if ({lb_re, video_de} !== 2'b11) begin failures++; $display("FAIL pre_reset_active got=%b want=11", {lb_re, video_de}); end
    hc = 11'd600; reset = 1'b1;
    #1;
    checks++; if ({lb_re, video_de} !== 2'b00) begin failures++; $display("FAIL reset_drop got=%b want=00", {lb_re, video_de}); end
    checks++; if ({lb_wbank, lb_rbank, video_hs} !== 3'b011) begin failures++; $display("FAIL reset_drop_bank_hs got=%b want=011", {lb_wbank, lb_rbank, video_hs}); end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_stats();
    run_hc(200, 601, 1367);
    exp_bank = 1'b1;
    checks++; if (de_n !== 0 || re_n !== 0 || we_n !== 0) begin failures++; $display("FAIL reset_remainder got de=%0d re=%0d we=%0d want=0", de_n, re_n, we_n); end
    checks++; if (lb_wbank !== exp_bank) begin failures++; $display("FAIL reset_swap_bank got=%b want=%b", lb_wbank, exp_bank); end
    run_line(201);
    checks++; if (de_n !== 720) begin failures++; $display("FAIL reset_resume_de got=%0d want=720", de_n); end
    checks++; if (we_n !== 512) begin failures++; $display("FAIL reset_resume_we got=%0d want=512", we_n); end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_capture();
    test_readout();
    test_vertical();
    test_enable_gap();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/video_out_lb_ctrl.md
# video_out_lb_ctrl

Sequencing controller for the video output line buffer. It captures one VDP line of 6-bit RGB into a ping-pong line buffer and reads the previous line back with horizontal magnification. It also generates the aligned `video_de`/`video_hs`/`video_vs` for the output stage. It sits between the VDP pixel outputs and the external dual-bank line-buffer RAM, and is driven by the VDP `vdp_hcounter`/`vdp_vcounter`.

## Interface
Parameters:
- `h_total`, 1368, VDP clocks per line (hcounter 0..h_total-1)
- `v_total`, 524, lines per frame
- `wr_h_start`, 200, hcounter at which capture window opens
- `wr_width`, 512, pixels captured per line (max 1024)
- `rd_h_start`, 240, hcounter at which readout opens
- `rd_width`, 720, output pixels per line (one per clk)
- `mag_step`, 728, read address step, 10-bit fraction (512/720·1024)
- `hs_start`, 0 / `hs_width`, 100, hsync window in hcounter
- `vs_line`, 0 / `vs_width`, 6, vsync window in output line index
- `v_active_start`, 40 / `v_active_lines`, 480, vertical DE window
- `hs_positive`, 1'b0 / `vs_positive`, 1'b0, sync polarity

Ports:
- `clk` in 1: VDP clock, 42.95454 MHz
- `reset` in 1: asynchronous, active-high
- `enable` in 1: VDP dot strobe, high every 2nd clk
- `vdp_r`, `vdp_g`, `vdp_b` in 6 each: VDP pixel
- `vdp_hcounter` in 11: horizontal position
- `vdp_vcounter` in 11: vertical position
- `lb_we` out 1: buffer write strobe
- `lb_wbank` out 1: write bank
- `lb_waddr` out 10: write address
- `lb_wdata` out 18: {r,g,b}
- `lb_re` out 1: buffer read strobe (RAM has 1-clk registered read)
- `lb_rbank` out 1: read bank, always ~`lb_wbank`
- `lb_raddr` out 10: read address
- `video_de`, `video_hs`, `video_vs` out 1: output timing, aligned with RAM read data

## Operation
- Write FSM: WAIT → CAPTURE when hcounter==wr_h_start; CAPTURE → DONE when wcount==wr_width; any state → WAIT at hcounter==h_total-1.
- In CAPTURE, each clk with `enable`=1 registers `lb_we`=1, `lb_waddr`=wcount, `lb_wdata`={vdp_r,vdp_g,vdp_b}, then wcount+1. With `enable`=0: `lb_we`=0 and wcount held.
- No write occurs past wr_width-1.
- Line swap at hcounter==h_total-1:
  - `lb_wbank` toggles
  - ly ← vdp_vcounter
  - line_valid ← 1
  - wcount ← 0
- Read FSM: IDLE → ACTIVE at hcounter==rd_h_start (acc←0); ACTIVE → IDLE after rd_width cycles.
- In ACTIVE, `lb_re`=1 every clk, `lb_raddr`=min(acc[19:10], wr_width-1), acc += mag_step. acc is 20 bits.
- Vertical: vact = line_valid && ly ∈ [v_active_start, v_active_start+v_active_lines).
- Horizontal sync: hs active when hcounter ∈ [hs_start, hs_start+hs_width).
- Vertical sync: vs active when ly ∈ [vs_line, vs_line+vs_width).
- Output is exactly one VDP line behind input. The read bank always holds a completed line.
- hcounter jumping without passing h_total-1: no swap occurs; FSMs are re-armed only by their start compares.

## Timing
- Reset values:
  - `lb_we`=0, `lb_re`=0, `lb_wbank`=0, `lb_rbank`=1, addresses=0, `lb_wdata`=0
  - `video_de`=0
  - `video_hs`/`video_vs` at inactive level (~hs_positive / ~vs_positive)
  - line_valid=0, ly=0
- Write latency: the pixel present at the clk edge with enable=1 appears on `lb_w*` one clk later.
- Read: `lb_re` is registered, first asserted 1 clk after hcounter==rd_h_start.
- Video timing: `video_de`/`hs`/`vs` are registered one further clk after `lb_re`, matching the RAM data valid cycle.
- `video_de` = lb_re(delayed 1) && vact.
- Until the first swap after reset, `video_de`=0. Syncs still run.
- Simultaneous swap and ACTIVE read is not allowed. Parameters must satisfy rd_h_start+rd_width < h_total-1; the bank changes only between readouts.
- Reset mid-line: all outputs return to reset values immediately (asynchronous). Capture restarts at the next wr_h_start. DE stays 0 until the following swap.

## Test plan
- Reset, then free-running counters with enable toggling: first line produces `video_de`=0 throughout; `lb_wbank` is 1 after the first hcounter==1367.
- Capture: pixel k driven at hcounter wr_h_start+2k → `lb_waddr`=k, `lb_wdata` equals that pixel, exactly 512 `lb_we` pulses per line, last address 511.
- Readout: count `lb_re` pulses = 720/line; `lb_raddr` sequence starts 0,0,1,2,2,3; final address ≤ 511; `lb_rbank` ≠ `lb_wbank` always.
- Vertical: ly=39 gives no DE; ly=40..519 give 720-clk DE each; vs active for ly 0..5, low-active with vs_positive=0.
- Enable held low for 10 clks inside the window: no writes, and address resumes without skip.
- Assert reset at hcounter 600 during read: `lb_re`, `video_de` drop the same cycle; DE is absent for the remainder of the frame's next line, then resumes.
